// File: rtl/chess_pkg.sv
// chess_pkg: shared state encoding, turn constants and default move-counter width for the chess timer
package chess_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN_W = 3'd2,
    RUN_B = 3'd3,
    PAUSE = 3'd4,
    FLAG  = 3'd5
  } state_t;
  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;
  localparam int MOVE_W_DEF = 8;
endpackage

// File: rtl/chess_turn_ctrl.sv
// chess_turn_ctrl: turn sequencer for the chess timer (player enables, preset load, set mode, flag fall, increments)
// Ports: clk/reset (sync, active-high); set/start/btn_w/btn_b one-cycle button pulses; zero_w/zero_b counter-empty levels;
//        setTime/count_w/count_b/flag_w/flag_b decode the state; load/inc_w/inc_b are registered pulses;
//        turn is the side to move; moves counts completed full moves and saturates.
module chess_turn_ctrl
  import chess_pkg::*;
#(
  parameter int MOVE_W = MOVE_W_DEF,
  parameter bit INC_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic              start,
  input  logic              btn_w,
  input  logic              btn_b,
  input  logic              zero_w,
  input  logic              zero_b,
  output logic              setTime,
  output logic              load,
  output logic              count_w,
  output logic              count_b,
  output logic              inc_w,
  output logic              inc_b,
  output logic              flag_w,
  output logic              flag_b,
  output logic              turn,
  output logic [MOVE_W-1:0] moves
);
  state_t state, nextState;
  logic pauseTurn, nextPauseTurn, nextTurn, nextLoad, nextIncW, nextIncB, bumpMoves, loadPending;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      turn        <= WHITE;
      pauseTurn   <= WHITE;
      moves       <= '0;
      load        <= 1'b0;
      inc_w       <= 1'b0;
      inc_b       <= 1'b0;
      loadPending <= 1'b1;
    end else begin
      state       <= nextState;
      turn        <= nextTurn;
      pauseTurn   <= nextPauseTurn;
      load        <= nextLoad;
      inc_w       <= nextIncW;
      inc_b       <= nextIncB;
      loadPending <= 1'b0;
      moves       <= nextLoad ? '0 : (bumpMoves && moves != '1) ? moves + 1'b1 : moves;
    end
  end
  // The post-reset load cycle swallows button inputs so load can never overlap a running counter.
  always_comb begin
    nextState     = state;
    nextTurn      = turn;
    nextPauseTurn = pauseTurn;
    nextLoad      = loadPending;
    nextIncW      = 1'b0;
    nextIncB      = 1'b0;
    bumpMoves     = 1'b0;
    if (!loadPending) begin
      case (state)
        IDLE:
          if (set) nextState = SET;
          else if (start) begin
            nextState = RUN_W;
            nextTurn  = WHITE;
          end
        SET:
          if (set) begin
            nextState = IDLE;
            nextLoad  = 1'b1;
          end
        RUN_W:
          if (zero_w) nextState = FLAG;
          else if (start) begin
            nextState     = PAUSE;
            nextPauseTurn = WHITE;
          end else if (btn_w) begin
            nextState = RUN_B;
            nextTurn  = BLACK;
            nextIncW  = INC_EN;
          end
        RUN_B:
          if (zero_b) nextState = FLAG;
          else if (start) begin
            nextState     = PAUSE;
            nextPauseTurn = BLACK;
          end else if (btn_b) begin
            nextState = RUN_W;
            nextTurn  = WHITE;
            nextIncB  = INC_EN;
            bumpMoves = 1'b1;
          end
        PAUSE:
          if (set) nextState = SET;
          else if (start) begin
            nextState = pauseTurn ? RUN_B : RUN_W;
            nextTurn  = pauseTurn;
          end
        FLAG:
          if (set) begin
            nextState = IDLE;
            nextLoad  = 1'b1;
          end
        default: nextState = IDLE;
      endcase
    end
    // A fresh game always starts with white to move.
    if (nextLoad) nextTurn = WHITE;
  end
  assign setTime = state == SET;
  assign count_w = state == RUN_W;
  assign count_b = state == RUN_B;
  // FLAG keeps the turn of the player who ran out, so the turn bit selects which flag is shown.
  assign flag_w  = state == FLAG && turn == WHITE;
  assign flag_b  = state == FLAG && turn == BLACK;
  a_count_excl: assert property (@(posedge clk) disable iff (reset) !(count_w && count_b));
  a_flag_excl:  assert property (@(posedge clk) disable iff (reset) !(flag_w && flag_b));
  a_load_idle:  assert property (@(posedge clk) disable iff (reset) !(load && (count_w || count_b)));
endmodule
